// File: rtl/interp_mu_gen.sv
// interp_mu_gen
//   Timing-control producer for the cubic interpolator. A phase accumulator
//   advances by a programmable step on every accepted word. Each phase value
//   is converted to a small float mu = phase / 2^PHASE_W in the 1/8/10 format
//   (sign, exponent bias 127, mantissa truncated). An accumulator wrap flags
//   that the next word belongs to a new input sample (load_x).
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst_n     synchronous active-low reset
//   en        start conversion of the next mu (sampled only in IDLE)
//   step      phase increment, sampled on the accepting handshake
//   mu_out    mu as a float word, stable while mu_valid is high
//   mu_valid  mu_out / load_x valid
//   mu_ready  consumer accepts the word when high together with mu_valid
//   load_x    with mu_valid: shift the x delay line before using this mu
//   busy      conversion or handshake in progress
//
// State table
//   IDLE  | waiting for en; phase holds the next value to convert
//   NORM  | shifting the phase copy left until its MSB is set (or it is zero)
//   VALID | word presented; waiting for mu_ready

module interp_mu_gen #(
  parameter int DATA_WIDTH = 19,
  parameter int PHASE_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PHASE_W-1:0]    step,
  output logic [DATA_WIDTH-1:0] mu_out,
  output logic                  mu_valid,
  input  logic                  mu_ready,
  output logic                  load_x,
  output logic                  busy
);

  localparam int CNT_W = $clog2(PHASE_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [PHASE_W-1:0]    phase, phase_nx;
  logic [PHASE_W-1:0]    sr, sr_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  first, first_nx;
  logic [DATA_WIDTH-1:0] mu_nx;
  logic [PHASE_W:0]      sum;
  logic [7:0]            exp_val;

  // Extra bit of the sum is the wrap carry that becomes the next load_x.
  assign sum     = {1'b0, phase} + {1'b0, step};
  // A normalized MSB at bit PHASE_W-1 is worth 0.5 (exponent 126); each
  // shift taken halves it.
  assign exp_val = 8'd126 - 8'(cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      phase  <= '0;
      first  <= 1'b1;
      sr     <= '0;
      cnt    <= '0;
      mu_out <= '0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      first  <= first_nx;
      sr     <= sr_nx;
      cnt    <= cnt_nx;
      mu_out <= mu_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    first_nx = first;
    sr_nx    = sr;
    cnt_nx   = cnt;
    mu_nx    = mu_out;

    case (state)
      IDLE: begin
        if (en) begin
          sr_nx    = phase;
          cnt_nx   = '0;
          state_nx = NORM;
        end
      end

      NORM: begin
        if (sr == '0) begin
          mu_nx    = '0;
          state_nx = VALID;
        end else if (sr[PHASE_W-1]) begin
          // Mantissa is the 10 bits below the leading one, truncated.
          mu_nx    = DATA_WIDTH'({1'b0, exp_val, sr[PHASE_W-2 -: 10]});
          state_nx = VALID;
        end else begin
          sr_nx  = sr << 1;
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      VALID: begin
        if (mu_ready) begin
          phase_nx = sum[PHASE_W-1:0];
          first_nx = sum[PHASE_W];
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // first only changes on the handshake, so load_x is stable through VALID.
  assign mu_valid = (state == VALID);
  assign load_x   = (state == VALID) && first;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_interp_mu_gen.sv
module tb_interp_mu_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] step;
  logic [18:0] mu_out;
  logic        mu_valid;
  logic        mu_ready;
  logic        load_x;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;

  // reference model state
  int unsigned m_phase;
  bit          m_first;

  always #5 clk = ~clk;

  interp_mu_gen #(.DATA_WIDTH(19), .PHASE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .step(step),
    .mu_out(mu_out), .mu_valid(mu_valid), .mu_ready(mu_ready),
    .load_x(load_x), .busy(busy)
  );

  typedef struct {
    logic [15:0] stp;
    logic [18:0] mu;
    logic        lx;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // mu = p / 65536 as a 1/8/10 float, mantissa truncated
  function automatic logic [18:0] mu_model(input int unsigned p);
    int k;
    int unsigned mant;
    logic [7:0]  e;
    if (p == 0) return 19'd0;
    k = 0;
    for (int i = 0; i < 16; i++) if (p >= (32'd1 << i)) k = i;
    e    = 8'(111 + k);
    mant = ((p - (32'd1 << k)) * 1024) >> k;
    return {1'b0, e, mant[9:0]};
  endfunction

  function automatic int lat_model(input int unsigned p);
    int k;
    if (p == 0) return 2;
    k = 0;
    for (int i = 0; i < 16; i++) if (p >= (32'd1 << i)) k = i;
    return 2 + (15 - k);
  endfunction

  task automatic model_hs(input logic [15:0] s);
    int unsigned t;
    t       = m_phase + 32'(s);
    m_first = (t >= 32'd65536);
    m_phase = t & 32'hFFFF;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    mu_ready = 1'b1;
    step     = '0;
    repeat (2) @(negedge clk);
    chk("rst_mu_valid", int'(mu_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_load_x", int'(load_x), 0);
    chk("rst_mu_out", int'(mu_out), 0);
    rst_n   = 1'b1;
    m_phase = 0;
    m_first = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where
  // mu_valid is first seen. mu_ready is left untouched.
  task automatic run_word(input logic [15:0] s, output logic [18:0] mu,
                          output logic lx, output int lat);
    bit ok;
    en  = 1'b1;
    step = s;
    lat = 0;
    ok  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      en = 1'b0;
      lat++;
      if (mu_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      total++;
      $display("FAIL timeout waiting for mu_valid after %0d cycles", lat);
    end
    mu = mu_out;
    lx = load_x;
  endtask

  task automatic handshake();
    mu_ready = 1'b1;
    @(negedge clk);
  endtask

  logic [18:0] mu_g, mu_h;
  logic        lx_g, lx_h;
  int          lat_g;

  initial begin
    tbl[0] = '{16'd8192, 19'h00000, 1'b1, 2};
    tbl[1] = '{16'd8192, 19'h1F000, 1'b0, 4};
    tbl[2] = '{16'd8192, 19'h1F400, 1'b0, 3};
    tbl[3] = '{16'd8192, 19'h1F600, 1'b0, 3};
    tbl[4] = '{16'd8192, 19'h1F800, 1'b0, 2};
    tbl[5] = '{16'd8192, 19'h1F900, 1'b0, 2};
    tbl[6] = '{16'd8192, 19'h1FA00, 1'b0, 2};
    tbl[7] = '{16'd8192, 19'h1FB00, 1'b0, 2};
    tbl[8] = '{16'd8192, 19'h00000, 1'b1, 2};

    // ramp with step 1/8, including wrap and latency
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_word(tbl[i].stp, mu_g, lx_g, lat_g);
      chk($sformatf("tbl%0d_mu", i), int'(mu_g), int'(tbl[i].mu));
      chk($sformatf("tbl%0d_lx", i), int'(lx_g), int'(tbl[i].lx));
      chk($sformatf("tbl%0d_lat", i), lat_g, tbl[i].lat);
      handshake();
      chk($sformatf("tbl%0d_idle", i), int'(busy), 0);
    end

    // backpressure holds the word and the phase
    do_reset();
    run_word(16'd8192, mu_g, lx_g, lat_g);
    handshake();
    mu_ready = 1'b0;
    run_word(16'd8192, mu_g, lx_g, lat_g);
    chk("bp_mu", int'(mu_g), 19'h1F000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(mu_valid), 1);
      chk("bp_hold_mu", int'(mu_out), int'(mu_g));
      chk("bp_hold_lx", int'(load_x), int'(lx_g));
    end
    handshake();
    chk("bp_after_valid", int'(mu_valid), 0);
    run_word(16'd8192, mu_g, lx_g, lat_g);
    chk("bp_next_mu", int'(mu_g), 19'h1F400);
    handshake();

    // truncation with step 0x5556
    do_reset();
    run_word(16'h5556, mu_g, lx_g, lat_g);
    chk("tr0_mu", int'(mu_g), 0);
    handshake();
    run_word(16'h5556, mu_g, lx_g, lat_g);
    chk("tr1_mu", int'(mu_g), 19'h1F555);
    chk("tr1_lx", int'(lx_g), 0);
    handshake();
    run_word(16'h5556, mu_g, lx_g, lat_g);
    chk("tr2_mu", int'(mu_g), 19'h1F955);
    handshake();

    // reset in the middle of a long normalization
    do_reset();
    run_word(16'd1, mu_g, lx_g, lat_g);
    handshake();
    en = 1'b1;
    step = 16'd1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", int'(mu_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_word(16'd1, mu_g, lx_g, lat_g);
    chk("mid_post_mu", int'(mu_g), 0);
    chk("mid_post_lx", int'(lx_g), 1);
    handshake();

    // step = 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_word(16'd0, mu_g, lx_g, lat_g);
      chk($sformatf("z%0d_mu", i), int'(mu_g), 0);
      chk($sformatf("z%0d_lx", i), int'(lx_g), (i == 0) ? 1 : 0);
      handshake();
    end

    // randomized steps, stalls and step changes during stalls
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int          n;
      logic [15:0] s;
      n = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: s = 16'($urandom_range(0, 15));
        1: s = 16'($urandom_range(16'hF000, 16'hFFFF));
        default: s = 16'($urandom);
      endcase
      mu_h = mu_model(m_phase);
      lx_h = m_first;
      mu_ready = (n == 0);
      run_word(s, mu_g, lx_g, lat_g);
      chk($sformatf("rnd%0d_mu", i), int'(mu_g), int'(mu_h));
      chk($sformatf("rnd%0d_lx", i), int'(lx_g), int'(lx_h));
      chk($sformatf("rnd%0d_lat", i), lat_g, lat_model(m_phase));
      for (int j = 0; j < n; j++) begin
        step = 16'($urandom);
        @(negedge clk);
        chk($sformatf("rnd%0d_stall_mu", i), int'(mu_out), int'(mu_h));
      end
      model_hs(step);
      handshake();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
